vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 800: visible pixels per line.
REQ-002 Parameter H_FRONT, default 40: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 128: hsync pulse width, in pixels.
REQ-004 Parameter H_BACK, default 88: horizontal back porch, in pixels.
REQ-005 Parameter V_ACTIVE, default 600: visible lines per frame.
REQ-006 Parameter V_FRONT, default 1: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 4: vsync pulse width, in lines.
REQ-008 Parameter V_BACK, default 23: vertical back porch, in lines.
REQ-009 clk  in  1  pixel clock, 40 MHz for the default 800x600@60 timing.
REQ-010 rst  in  1  reset; synchronous, active-high.
REQ-011 out  itf_vga_no_rgb.out  -  hcount[10:0], vcount[10:0], hsync, hblnk, vsync, vblnk; this is the timing stream consumed by draw_bg and the downstream drawing chain.
REQ-012 frame_start  out  1  single-cycle pulse marking pixel (0,0) of a new frame.

Function
REQ-013 H_TOTAL SHALL equal H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 1056).
REQ-014 V_TOTAL SHALL equal V_ACTIVE+V_FRONT+V_SYNC+V_BACK (default 628).
REQ-015 The block SHALL elaborate only when H_TOTAL<=2048 and V_TOTAL<=2048; otherwise it SHALL raise an elaboration error.
REQ-016 hcount SHALL increment by 1 on every clock edge with rst low, wrapping from H_TOTAL-1 to 0.
REQ-017 vcount SHALL increment by 1 only on the edge where hcount wraps, wrapping from V_TOTAL-1 to 0.
REQ-018 All outputs SHALL be registered, with no combinational path to any port.
REQ-019 hblnk SHALL be 1 exactly when the hcount output in the same cycle satisfies hcount>=H_ACTIVE (default 800..1055).
REQ-020 hsync SHALL be 1 exactly when H_ACTIVE+H_FRONT <= hcount < H_ACTIVE+H_FRONT+H_SYNC (default 840..967); polarity is active-high.
REQ-021 vblnk SHALL be 1 exactly when vcount>=V_ACTIVE (default 600..627), for the entire line including all hcount values.
REQ-022 vsync SHALL be 1 exactly when V_ACTIVE+V_FRONT <= vcount < V_ACTIVE+V_FRONT+V_SYNC (default 601..604); polarity is active-high.
REQ-023 Flags SHALL be computed from the next-count values and registered alongside the counters, so that flags and counts are cycle-aligned with zero skew.
REQ-024 frame_start SHALL be 1 for exactly one cycle, in the cycle where the outputs present hcount=0 and vcount=0 as a result of a wrap.
REQ-025 Frame period SHALL be exactly H_TOTAL*V_TOTAL cycles (default 663168), with no dropped or repeated pixel.
REQ-026 Simultaneous horizontal and vertical wrap, at hcount=H_TOTAL-1 and vcount=V_TOTAL-1, SHALL produce (0,0) with frame_start=1 on the next cycle.
REQ-027 Counters SHALL never present a value >= the corresponding TOTAL.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL force hcount=0, vcount=0, hsync=0, hblnk=0, vsync=0, vblnk=0 and frame_start=0.
REQ-029 On the first edge with rst=0, the block SHALL present hcount=1, vcount=0; frame_start SHALL NOT pulse on reset exit.
REQ-030 rst asserted mid-frame SHALL restart timing from (0,0) on that edge, with no partial sync pulse continuing past reset.
REQ-031 Reset behaviour SHALL be identical regardless of the current counter state or flag state.

Verification
REQ-032 Reset is held 3 cycles then released -> the bench observes (0,0) with all flags 0 during reset, then hcount=1,2,3 and vcount=0.
REQ-033 A full line is run -> hblnk rises at hcount=800 and falls at 0, hsync is high for 128 cycles starting at 840, and vcount steps 0->1 when hcount returns to 0 after 1055.
REQ-034 A full frame is run -> vblnk is high for lines 600..627, vsync is high for lines 601..604 (4*1056 cycles), and frame_start pulses once when the counts wrap to (0,0) after (1055,627).
REQ-035 Consecutive frame_start pulses are measured -> the spacing is exactly 663168 cycles, and no pulse appears in between.
REQ-036 rst is asserted at hcount=900, vcount=602 (inside vsync and hsync) -> next cycle shows (0,0) with all flags 0; the first frame_start appears 663168 cycles after release.
REQ-037 An instance with reduced parameters (H 8/2/2/2, V 4/1/1/1) is run -> the same flag equations hold, with a 14x7 period and frame_start every 98 cycles.

Source files
------------

// File: rtl/vga_timing_if.sv
// Timing stream without pixel colour: counters plus sync/blank flags.
// Consumed by draw_bg and the downstream drawing chain.
//   hcount, vcount : current pixel/line position
//   hsync, vsync   : active-high sync pulses
//   hblnk, vblnk   : active-high blanking flags
// Modports: out/master drive the stream, slave consumes it.
interface itf_vga_no_rgb;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        hblnk;
   logic        vsync;
   logic        vblnk;

   modport out    (output hcount, vcount, hsync, hblnk, vsync, vblnk);
   modport master (output hcount, vcount, hsync, hblnk, vsync, vblnk);
   modport slave  (input  hcount, vcount, hsync, hblnk, vsync, vblnk);
endinterface

// File: rtl/vga_timing.sv
// VGA timing generator: free-running pixel/line counters with registered
// sync and blanking flags, plus a one-cycle frame_start pulse at (0,0).
// Ports:
//   clk         : pixel clock
//   rst         : synchronous, active-high reset
//   out         : timing stream (hcount, vcount, hsync, hblnk, vsync, vblnk)
//   frame_start : one-cycle pulse when the counts wrap to (0,0)
module vga_timing #(
   parameter int unsigned H_ACTIVE = 800,
   parameter int unsigned H_FRONT  = 40,
   parameter int unsigned H_SYNC   = 128,
   parameter int unsigned H_BACK   = 88,
   parameter int unsigned V_ACTIVE = 600,
   parameter int unsigned V_FRONT  = 1,
   parameter int unsigned V_SYNC   = 4,
   parameter int unsigned V_BACK   = 23
) (
   input  logic              clk,
   input  logic              rst,
   itf_vga_no_rgb.out        out,
   output logic              frame_start
);

   localparam int unsigned CW      = 11;
   localparam int unsigned EW      = CW + 1;
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   // Counters are 11 bits wide, so totals beyond 2048 cannot be represented.
   if (H_TOTAL > 2048 || V_TOTAL > 2048 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_size_check
      $error("vga_timing: H_TOTAL and V_TOTAL must be within 1..2048");
   end

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

   // Flag thresholds held one bit wider so a boundary of exactly 2048 still compares.
   localparam logic [EW-1:0] H_BLNK_LO = EW'(H_ACTIVE);
   localparam logic [EW-1:0] H_SYNC_LO = EW'(H_ACTIVE + H_FRONT);
   localparam logic [EW-1:0] H_SYNC_HI = EW'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [EW-1:0] V_BLNK_LO = EW'(V_ACTIVE);
   localparam logic [EW-1:0] V_SYNC_LO = EW'(V_ACTIVE + V_FRONT);
   localparam logic [EW-1:0] V_SYNC_HI = EW'(V_ACTIVE + V_FRONT + V_SYNC);

   logic          h_wrap_c;
   logic          v_wrap_c;
   logic [CW-1:0] hcount_nxt_c;
   logic [CW-1:0] vcount_nxt_c;
   logic [EW-1:0] h_ext_c;
   logic [EW-1:0] v_ext_c;
   logic          hsync_nxt_c;
   logic          hblnk_nxt_c;
   logic          vsync_nxt_c;
   logic          vblnk_nxt_c;
   logic          frame_start_nxt_c;

   // Next-count values; flags derive from these so they register in step with the counts.
   always_comb begin
      h_wrap_c          = (out.hcount == H_LAST);
      v_wrap_c          = (out.vcount == V_LAST);
      hcount_nxt_c      = h_wrap_c ? '0 : out.hcount + CW'(1);
      vcount_nxt_c      = out.vcount;
      if (h_wrap_c) begin
         vcount_nxt_c = v_wrap_c ? '0 : out.vcount + CW'(1);
      end
      h_ext_c           = EW'(hcount_nxt_c);
      v_ext_c           = EW'(vcount_nxt_c);
      hblnk_nxt_c       = (h_ext_c >= H_BLNK_LO);
      hsync_nxt_c       = (h_ext_c >= H_SYNC_LO) && (h_ext_c < H_SYNC_HI);
      vblnk_nxt_c       = (v_ext_c >= V_BLNK_LO);
      vsync_nxt_c       = (v_ext_c >= V_SYNC_LO) && (v_ext_c < V_SYNC_HI);
      // Only a genuine double wrap marks a new frame; leaving reset never does.
      frame_start_nxt_c = h_wrap_c && v_wrap_c;
   end

   // Output registers; reset restarts timing from (0,0) with every flag cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         out.hcount  <= '0;
         out.vcount  <= '0;
         out.hsync   <= 1'b0;
         out.hblnk   <= 1'b0;
         out.vsync   <= 1'b0;
         out.vblnk   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         out.hcount  <= hcount_nxt_c;
         out.vcount  <= vcount_nxt_c;
         out.hsync   <= hsync_nxt_c;
         out.hblnk   <= hblnk_nxt_c;
         out.vsync   <= vsync_nxt_c;
         out.vblnk   <= vblnk_nxt_c;
         frame_start <= frame_start_nxt_c;
      end
   end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 800x600 instance and a reduced 14x7 instance,
// both compared every cycle against a position-index model, plus literal checks.
module tb_vga_timing;

   logic clk = 1'b0;
   logic rst_d = 1'b1;
   logic rst_s = 1'b1;
   logic fs_d;
   logic fs_s;

   int checks   = 0;
   int failures = 0;

   itf_vga_no_rgb vif_d ();
   itf_vga_no_rgb vif_s ();

   always #5 clk = ~clk;

   vga_timing dut_d (
      .clk         (clk),
      .rst         (rst_d),
      .out         (vif_d),
      .frame_start (fs_d)
   );

   vga_timing #(
      .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
      .V_ACTIVE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
   ) dut_s (
      .clk         (clk),
      .rst         (rst_s),
      .out         (vif_s),
      .frame_start (fs_s)
   );

   // Expected outputs from p = number of non-reset edges since the last reset edge.
   // Packing: {hcount[10:0], vcount[10:0], hsync, hblnk, vsync, vblnk, frame_start}
   function automatic logic [26:0] model(input longint p,
                                         input longint ha, input longint hf,
                                         input longint hs, input longint hb,
                                         input longint va, input longint vf,
                                         input longint vs, input longint vb);
      longint ht = ha + hf + hs + hb;
      longint vt = va + vf + vs + vb;
      longint h  = p % ht;
      longint v  = (p / ht) % vt;
      logic   e_hs = (h >= ha + hf) && (h < ha + hf + hs);
      logic   e_hb = (h >= ha);
      logic   e_vs = (v >= va + vf) && (v < va + vf + vs);
      logic   e_vb = (v >= va);
      logic   e_fs = (p > 0) && (p % (ht * vt) == 0);
      return {11'(h), 11'(v), e_hs, e_hb, e_vs, e_vb, e_fs};
   endfunction

   longint p_d = 0;
   longint p_s = 0;
   bit     valid_d = 1'b0;
   bit     valid_s = 1'b0;

   always @(posedge clk) begin
      if (rst_d) begin
         p_d <= 0; valid_d <= 1'b1;
      end else begin
         p_d <= p_d + 1;
      end
      if (rst_s) begin
         p_s <= 0; valid_s <= 1'b1;
      end else begin
         p_s <= p_s + 1;
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      logic [26:0] act;
      logic [26:0] exp;
      if (valid_d) begin
         act = {vif_d.hcount, vif_d.vcount, vif_d.hsync, vif_d.hblnk, vif_d.vsync, vif_d.vblnk, fs_d};
         exp = model(p_d, 800, 40, 128, 88, 600, 1, 4, 23);
         checks++;
         if (act !== exp) begin
            failures++;
            $display("FAIL model_default p=%0d got h=%0d v=%0d hs/hb/vs/vb/fs=%b required h=%0d v=%0d hs/hb/vs/vb/fs=%b",
                     p_d, act[26:16], act[15:5], act[4:0], exp[26:16], exp[15:5], exp[4:0]);
         end
      end
      if (valid_s) begin
         act = {vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.hblnk, vif_s.vsync, vif_s.vblnk, fs_s};
         exp = model(p_s, 8, 2, 2, 2, 4, 1, 1, 1);
         checks++;
         if (act !== exp) begin
            failures++;
            $display("FAIL model_small p=%0d got h=%0d v=%0d hs/hb/vs/vb/fs=%b required h=%0d v=%0d hs/hb/vs/vb/fs=%b",
                     p_s, act[26:16], act[15:5], act[4:0], exp[26:16], exp[15:5], exp[4:0]);
         end
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got %0d required %0d", name, act, exp);
      end
   endtask

   initial begin
      int n;
      int k;
      int hs_cnt;
      int hb_cnt;
      bit found;

      // Reset held three cycles: everything zero.
      repeat (3) @(negedge clk);
      check("rst_hcount", longint'(vif_d.hcount), 0);
      check("rst_vcount", longint'(vif_d.vcount), 0);
      check("rst_flags", longint'({vif_d.hsync, vif_d.hblnk, vif_d.vsync, vif_d.vblnk, fs_d}), 0);
      rst_d = 1'b0;
      rst_s = 1'b0;

      // First edges after release count 1,2,3 on line 0.
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("exit_hcount", longint'(vif_d.hcount), longint'(i));
         check("exit_vcount", longint'(vif_d.vcount), 0);
         check("exit_fs", longint'(fs_d), 0);
      end

      // Line 0 remainder: hblnk starts at 800, hsync spans 840..967, then line 1 begins.
      hs_cnt = 0; hb_cnt = 0; found = 1'b0;
      for (int i = 0; i < 1100; i++) begin
         if (vif_d.hcount == 11'd840) check("hsync_at_840", longint'(vif_d.hsync), 1);
         if (vif_d.hcount == 11'd839) check("hsync_at_839", longint'(vif_d.hsync), 0);
         if (vif_d.hcount == 11'd800) check("hblnk_at_800", longint'(vif_d.hblnk), 1);
         if (vif_d.hcount == 11'd799) check("hblnk_at_799", longint'(vif_d.hblnk), 0);
         hs_cnt += int'(vif_d.hsync);
         hb_cnt += int'(vif_d.hblnk);
         @(negedge clk);
         if (vif_d.hcount == 11'd0) begin
            found = 1'b1;
            break;
         end
      end
      check("line_wrap_seen", longint'(found), 1);
      check("line1_vcount", longint'(vif_d.vcount), 1);
      check("line1_hblnk", longint'(vif_d.hblnk), 0);
      check("hsync_width", longint'(hs_cnt), 128);
      check("hblnk_width", longint'(hb_cnt), 256);

      // Reduced instance: reset inside both sync pulses, then time to the first frame_start.
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (vif_s.hsync && vif_s.vsync) begin
            found = 1'b1;
            break;
         end
      end
      check("small_sync_overlap_seen", longint'(found), 1);
      check("small_overlap_h", longint'(vif_s.hcount), 10);
      check("small_overlap_v", longint'(vif_s.vcount), 5);
      rst_s = 1'b1;
      @(negedge clk);
      check("small_midrst_h", longint'(vif_s.hcount), 0);
      check("small_midrst_v", longint'(vif_s.vcount), 0);
      check("small_midrst_flags", longint'({vif_s.hsync, vif_s.hblnk, vif_s.vsync, vif_s.vblnk, fs_s}), 0);
      rst_s = 1'b0;
      for (int f = 0; f < 2; f++) begin
         k = 0; n = 0; found = 1'b0;
         for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (fs_s) begin
               k = i; found = 1'b1;
               break;
            end
         end
         check("small_fs_spacing", longint'(k), 98);
         check("small_fs_at_origin", longint'({vif_s.hcount, vif_s.vcount}), 0);
      end

      // Randomized resets on both instances; the model is checked every cycle.
      for (int i = 0; i < 15000; i++) begin
         @(negedge clk);
         if (!rst_s && $urandom_range(0, 299) == 0) begin
            rst_s = 1'b1;
            n = int'($urandom_range(1, 3));
         end else if (rst_s && --n <= 0) begin
            rst_s = 1'b0;
         end
         if (!rst_d && $urandom_range(0, 3999) == 0) rst_d = 1'b1;
         else if (rst_d) rst_d = 1'b0;
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
